// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the load/store CPU fetch/decode slice.
//   - opcode constants carried in instr[31:28]
//   - instruction field positions/widths and a field-extraction helper
//   - fetch/decode bus FSM state encoding
package cpu_pkg;

  // Opcodes (instr[31:28])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_JUMP = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_PUSH = 4'h8;
  localparam logic [3:0] OP_POP  = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  // Instruction field layout (32-bit instruction word)
  localparam int INSTR_W  = 32;
  localparam int OPC_LSB  = 28;
  localparam int OPC_W    = 4;
  localparam int EXT_LSB  = 24;
  localparam int EXT_W    = 4;
  localparam int OPA_LSB  = 20;
  localparam int OPA_W    = 4;
  localparam int OPB_LSB  = 16;
  localparam int OPB_W    = 4;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 16;

  // Bus FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DEC  = 2'd3
  } fd_state_e;

  // Decoded instruction fields
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [EXT_W-1:0] extra;
    logic [OPA_W-1:0] operand_a;
    logic [OPB_W-1:0] operand_b;
    logic [IMM_W-1:0] immediate;
  } fd_fields_t;

  // Split a 32-bit instruction word into its fields
  function automatic fd_fields_t decode_instr(input logic [INSTR_W-1:0] instr);
    fd_fields_t f;
    f.opcode    = instr[OPC_LSB +: OPC_W];
    f.extra     = instr[EXT_LSB +: EXT_W];
    f.operand_a = instr[OPA_LSB +: OPA_W];
    f.operand_b = instr[OPB_LSB +: OPB_W];
    f.immediate = instr[IMM_LSB +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/wb_access.sv
// wb_access: single-transaction pipelined Wishbone master with request FSM.
//   IDLE -> REQ -> WAIT -> (DEC) -> IDLE. One request in flight; new
//   requests are only accepted in IDLE (never queued).
// Configuration macro: FETCH_DECODE_STALL_EN
//   defined   : i_wb_stall holds stb high until the slave accepts it
//   undefined : i_wb_stall ignored, stb is high for exactly one cycle
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_enable/i_addr/i_we/
//   i_wdata/i_ifetch           request, sampled only in IDLE
//   o_rdata                    last read data (held until next read)
//   o_done                     1-cycle completion pulse
//   o_dec_fire                 high for the one cycle the top must register decode fields
//   o_wb_*/i_wb_*              Wishbone master interface
module wb_access
  import cpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ifetch,
  output logic [DW-1:0] o_rdata,
  output logic          o_done,
  output logic          o_dec_fire,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall
);

  fd_state_e     state_r, state_next_s;
  logic          cyc_r, cyc_next_s;
  logic          stb_r, stb_next_s;
  logic          we_r, we_next_s;
  logic [AW-1:0] addr_r, addr_next_s;
  logic [DW-1:0] wdata_r, wdata_next_s;
  logic          ifetch_r, ifetch_next_s;
  logic [DW-1:0] rdata_r, rdata_next_s;
  logic          done_r, done_next_s;
  logic          stall_s;

`ifdef FETCH_DECODE_STALL_EN
  assign stall_s = i_wb_stall;
`else
  logic unused_stall_s;
  assign unused_stall_s = i_wb_stall;
  assign stall_s        = 1'b0;
`endif

  // Next-state and next-output logic; ack while still stalled counts as completion
  always_comb begin
    state_next_s  = state_r;
    cyc_next_s    = cyc_r;
    stb_next_s    = stb_r;
    we_next_s     = we_r;
    addr_next_s   = addr_r;
    wdata_next_s  = wdata_r;
    ifetch_next_s = ifetch_r;
    rdata_next_s  = rdata_r;
    done_next_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          cyc_next_s    = 1'b1;
          stb_next_s    = 1'b1;
          we_next_s     = i_we;
          addr_next_s   = i_addr;
          wdata_next_s  = i_wdata;
          ifetch_next_s = i_ifetch;
          state_next_s  = ST_REQ;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (i_wb_ack) begin
          cyc_next_s  = 1'b0;
          stb_next_s  = 1'b0;
          we_next_s   = 1'b0;
          done_next_s = 1'b1;
          if (!we_r) begin
            rdata_next_s = i_wb_data;
          end else begin
            rdata_next_s = rdata_r;
          end
          if (!we_r && ifetch_r) begin
            state_next_s = ST_DEC;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else if ((state_r == ST_REQ) && !stall_s) begin
          stb_next_s   = 1'b0;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DEC: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        cyc_next_s   = 1'b0;
        stb_next_s   = 1'b0;
        we_next_s    = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops cyc/stb even mid-transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cyc_r    <= 1'b0;
      stb_r    <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= {AW{1'b0}};
      wdata_r  <= {DW{1'b0}};
      ifetch_r <= 1'b0;
      rdata_r  <= {DW{1'b0}};
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cyc_r    <= cyc_next_s;
      stb_r    <= stb_next_s;
      we_r     <= we_next_s;
      addr_r   <= addr_next_s;
      wdata_r  <= wdata_next_s;
      ifetch_r <= ifetch_next_s;
      rdata_r  <= rdata_next_s;
      done_r   <= done_next_s;
    end
  end

  assign o_rdata    = rdata_r;
  assign o_done     = done_r;
  assign o_dec_fire = (state_r == ST_DEC);
  assign o_wb_cyc   = cyc_r;
  assign o_wb_stb   = stb_r;
  assign o_wb_we    = we_r;
  assign o_wb_addr  = addr_r;
  assign o_wb_data  = wdata_r;

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: Wishbone (pipelined) master plus instruction field decoder.
//   Instruction fetches read a word then register its fields one cycle after
//   o_done (o_decoded pulses then). Data loads/stores never decode.
// Configuration macro: FETCH_DECODE_STALL_EN (handled inside wb_access)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_enable ... i_ifetch request inputs (sampled only when idle)
//   o_rdata, o_done       last read data, completion pulse
//   o_decoded             decode-valid pulse
//   o_opcode/o_extra/
//   o_operandA/o_operandB/
//   o_immediate           decoded fields, held until next decode
//   o_wb_*/i_wb_*         Wishbone master interface
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ifetch,
  output logic [DW-1:0] o_rdata,
  output logic          o_done,
  output logic          o_decoded,
  output logic [3:0]    o_opcode,
  output logic [3:0]    o_extra,
  output logic [3:0]    o_operandA,
  output logic [3:0]    o_operandB,
  output logic [15:0]   o_immediate,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall
);

  logic       dec_fire_s;
  fd_fields_t dec_s;
  fd_fields_t fields_r;
  logic       decoded_r;

  wb_access #(.AW(AW), .DW(DW)) u_wb_access (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (i_enable),
    .i_addr     (i_addr),
    .i_we       (i_we),
    .i_wdata    (i_wdata),
    .i_ifetch   (i_ifetch),
    .o_rdata    (o_rdata),
    .o_done     (o_done),
    .o_dec_fire (dec_fire_s),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .i_wb_data  (i_wb_data),
    .i_wb_ack   (i_wb_ack),
    .i_wb_stall (i_wb_stall)
  );

  assign dec_s = decode_instr(o_rdata[INSTR_W-1:0]);

  // Decode registers: capture fields from the freshly read word; zero fields decode as NOP
  always_ff @(posedge clk) begin
    if (reset) begin
      fields_r  <= '{opcode: OP_NOP, extra: 4'h0, operand_a: 4'h0,
                     operand_b: 4'h0, immediate: 16'h0000};
      decoded_r <= 1'b0;
    end else if (dec_fire_s) begin
      fields_r  <= dec_s;
      decoded_r <= 1'b1;
    end else begin
      decoded_r <= 1'b0;
    end
  end

  assign o_decoded   = decoded_r;
  assign o_opcode    = fields_r.opcode;
  assign o_extra     = fields_r.extra;
  assign o_operandA  = fields_r.operand_a;
  assign o_operandB  = fields_r.operand_b;
  assign o_immediate = fields_r.immediate;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed self-checking bench for fetch_decode.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [31:0] i_addr;
  logic        i_we;
  logic [31:0] i_wdata;
  logic        i_ifetch;
  logic [31:0] o_rdata;
  logic        o_done;
  logic        o_decoded;
  logic [3:0]  o_opcode;
  logic [3:0]  o_extra;
  logic [3:0]  o_operandA;
  logic [3:0]  o_operandB;
  logic [15:0] o_immediate;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;

  int checks_n = 0;
  int errors_n = 0;
  int done_cnt;
  int cyc_cnt;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (i_enable),
    .i_addr      (i_addr),
    .i_we        (i_we),
    .i_wdata     (i_wdata),
    .i_ifetch    (i_ifetch),
    .o_rdata     (o_rdata),
    .o_done      (o_done),
    .o_decoded   (o_decoded),
    .o_opcode    (o_opcode),
    .o_extra     (o_extra),
    .o_operandA  (o_operandA),
    .o_operandB  (o_operandB),
    .o_immediate (o_immediate),
    .o_wb_cyc    (o_wb_cyc),
    .o_wb_stb    (o_wb_stb),
    .o_wb_we     (o_wb_we),
    .o_wb_addr   (o_wb_addr),
    .o_wb_data   (o_wb_data),
    .i_wb_data   (i_wb_data),
    .i_wb_ack    (i_wb_ack),
    .i_wb_stall  (i_wb_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    i_enable   = 1'b0;
    i_addr     = 32'h0;
    i_we       = 1'b0;
    i_wdata    = 32'h0;
    i_ifetch   = 1'b0;
    i_wb_data  = 32'h0;
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_cyc",  {31'd0, o_wb_cyc},  32'd0);
    check("rst_stb",  {31'd0, o_wb_stb},  32'd0);
    check("rst_done", {31'd0, o_done},    32'd0);
    check("rst_dec",  {31'd0, o_decoded}, 32'd0);
    check("rst_opc",  {28'd0, o_opcode},  32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_addr",  o_wb_addr, 32'd0);

    // 1: instruction fetch, ack one cycle after stb
    i_enable = 1'b1; i_addr = 32'hB000_0000; i_we = 1'b0; i_ifetch = 1'b1;
    tick();
    i_enable = 1'b0;
    check("t1_cyc",  {31'd0, o_wb_cyc}, 32'd1);
    check("t1_stb",  {31'd0, o_wb_stb}, 32'd1);
    check("t1_we",   {31'd0, o_wb_we},  32'd0);
    check("t1_addr", o_wb_addr, 32'hB000_0000);
    tick();
    check("t1_stb_drop", {31'd0, o_wb_stb}, 32'd0);
    check("t1_cyc_hold", {31'd0, o_wb_cyc}, 32'd1);
    check("t1_nodone",   {31'd0, o_done},   32'd0);
    i_wb_ack = 1'b1; i_wb_data = 32'h4A12_0034;
    tick();
    i_wb_ack = 1'b0; i_wb_data = 32'h0;
    check("t1_done",   {31'd0, o_done},    32'd1);
    check("t1_cyc_lo", {31'd0, o_wb_cyc},  32'd0);
    check("t1_rdata",  o_rdata, 32'h4A12_0034);
    check("t1_dec_early", {31'd0, o_decoded}, 32'd0);
    tick();
    check("t1_done_lo", {31'd0, o_done},    32'd0);
    check("t1_decoded", {31'd0, o_decoded}, 32'd1);
    check("t1_opcode",  {28'd0, o_opcode},   32'h4);
    check("t1_extra",   {28'd0, o_extra},    32'hA);
    check("t1_opA",     {28'd0, o_operandA}, 32'h1);
    check("t1_opB",     {28'd0, o_operandB}, 32'h2);
    check("t1_imm",     {16'd0, o_immediate}, 32'h0034);
    tick();
    check("t1_dec_pulse", {31'd0, o_decoded}, 32'd0);
    check("t1_opc_hold",  {28'd0, o_opcode},  32'h4);

    // 2: write, ack in the same cycle stb is accepted
    i_enable = 1'b1; i_addr = 32'hB000_FFFC; i_we = 1'b1; i_wdata = 32'hDEAD_BEEF; i_ifetch = 1'b1;
    tick();
    i_enable = 1'b0; i_we = 1'b0; i_wdata = 32'h0;
    check("t2_we",    {31'd0, o_wb_we}, 32'd1);
    check("t2_wdata", o_wb_data, 32'hDEAD_BEEF);
    check("t2_addr",  o_wb_addr, 32'hB000_FFFC);
    i_wb_ack = 1'b1; i_wb_data = 32'h1111_2222;
    tick();
    i_wb_ack = 1'b0; i_wb_data = 32'h0;
    check("t2_done",  {31'd0, o_done},   32'd1);
    check("t2_we_lo", {31'd0, o_wb_we},  32'd0);
    check("t2_stb_lo", {31'd0, o_wb_stb}, 32'd0);
    check("t2_rdata", o_rdata, 32'h4A12_0034);
    tick();
    check("t2_nodec", {31'd0, o_decoded}, 32'd0);
    check("t2_opc",   {28'd0, o_opcode},  32'h4);
    check("t2_wdata_hold", o_wb_data, 32'hDEAD_BEEF);

    // 3: stall behaviour (honoured or ignored depending on build)
    i_enable = 1'b1; i_addr = 32'h0000_0100; i_we = 1'b0; i_ifetch = 1'b0; i_wb_stall = 1'b1;
    tick();
    i_enable = 1'b0;
    check("t3_stb0", {31'd0, o_wb_stb}, 32'd1);
`ifdef FETCH_DECODE_STALL_EN
    tick();
    check("t3_stb1", {31'd0, o_wb_stb}, 32'd1);
    tick();
    check("t3_stb2", {31'd0, o_wb_stb}, 32'd1);
    check("t3_nodone", {31'd0, o_done}, 32'd0);
    i_wb_stall = 1'b0;
`else
    tick();
    check("t3_stb_ign", {31'd0, o_wb_stb}, 32'd0);
    check("t3_cyc",     {31'd0, o_wb_cyc}, 32'd1);
`endif
    i_wb_ack = 1'b1; i_wb_data = 32'h1234_5678;
    tick();
    i_wb_ack = 1'b0; i_wb_data = 32'h0; i_wb_stall = 1'b0;
    check("t3_done",  {31'd0, o_done},   32'd1);
    check("t3_stb_lo", {31'd0, o_wb_stb}, 32'd0);
    check("t3_rdata", o_rdata, 32'h1234_5678);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_done) done_cnt++;
    end
    check("t3_done_once", done_cnt, 32'd0);
    check("t3_nodec", {31'd0, o_decoded}, 32'd0);

    // 4: reset mid-transaction
    i_enable = 1'b1; i_addr = 32'h0000_0200; i_we = 1'b0; i_ifetch = 1'b1;
    tick();
    i_enable = 1'b0;
    check("t4_cyc", {31'd0, o_wb_cyc}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_cyc_lo", {31'd0, o_wb_cyc}, 32'd0);
    check("t4_stb_lo", {31'd0, o_wb_stb}, 32'd0);
    check("t4_rdata",  o_rdata, 32'd0);
    check("t4_opc",    {28'd0, o_opcode}, 32'd0);
    check("t4_addr",   o_wb_addr, 32'd0);
    i_wb_ack = 1'b1; i_wb_data = 32'hFFFF_FFFF;
    tick();
    i_wb_ack = 1'b0; i_wb_data = 32'h0;
    check("t4_ack_ign", {31'd0, o_done}, 32'd0);
    check("t4_rdata2",  o_rdata, 32'd0);
    tick();
    check("t4_nodec", {31'd0, o_decoded}, 32'd0);

    // 5: i_enable during WAIT is ignored
    i_enable = 1'b1; i_addr = 32'h0000_0300; i_we = 1'b0; i_ifetch = 1'b0;
    tick();
    i_enable = 1'b0;
    tick();
    i_enable = 1'b1; i_addr = 32'h0000_0400;
    tick();
    i_enable = 1'b0;
    check("t5_cyc",  {31'd0, o_wb_cyc}, 32'd1);
    check("t5_addr", o_wb_addr, 32'h0000_0300);
    i_wb_ack = 1'b1; i_wb_data = 32'h55AA_55AA;
    tick();
    i_wb_ack = 1'b0; i_wb_data = 32'h0;
    check("t5_done",  {31'd0, o_done}, 32'd1);
    check("t5_rdata", o_rdata, 32'h55AA_55AA);
    done_cnt = 0;
    cyc_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_done) done_cnt++;
      if (o_wb_cyc) cyc_cnt++;
    end
    check("t5_no_extra_done", done_cnt, 32'd0);
    check("t5_no_extra_cyc",  cyc_cnt,  32'd0);
    check("t5_addr_hold", o_wb_addr, 32'h0000_0300);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
